water_led_multi: RTL and testbench

Parametrised successor to the 4-LED flowing-light driver. Drives LED_NUM LEDs with a selectable animation mode, a run-time speed divider and a pause/enable input, and emits a step strobe. It sits directly behind the board LED pins. The prescaler length remains a parameter so benches can shorten it.

---
 rtl/water_led_multi.sv | 124 ++++++++++++
 tb/tb_water_led_multi.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/water_led_multi.sv
// LED_NUM-wide flowing-light driver: rotate/bounce/fill animations, run-time speed
// divider, pause input and a one-cycle step strobe. All outputs are registered.
module water_led_multi #(
  parameter int               LED_NUM    = 4,
  parameter int               CNT_W      = 25,
  parameter logic [CNT_W-1:0] CNT_MAX    = CNT_W'(24_999_999),
  parameter bit               ACTIVE_LOW = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [1:0]         speed,
  output logic [LED_NUM-1:0] led_out,
  output logic               step_o
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  localparam logic [LED_NUM-1:0] PAT_INIT = {{(LED_NUM-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         step_cnt_q, step_cnt_d;
  logic [LED_NUM-1:0] pattern_q, pattern_d;
  dir_t               dir_q, dir_d;
  logic [1:0]         mode_q, mode_d;
  logic               step_q, step_d;

  logic               tick;
  logic               step;
  logic [2:0]         step_lim;
  logic [LED_NUM-1:0] pat_adv;
  dir_t               dir_adv;

  always_comb begin
    case (speed)
      2'd0:    step_lim = 3'd0;
      2'd1:    step_lim = 3'd1;
      2'd2:    step_lim = 3'd3;
      default: step_lim = 3'd7;
    endcase
  end

  // >= rather than == so that lowering speed mid-count fires at the next tick.
  assign tick = en && (cnt_q == CNT_MAX);
  assign step = tick && (step_cnt_q >= step_lim);

  always_comb begin
    pat_adv = pattern_q;
    dir_adv = dir_q;
    case (mode_q)
      2'b00: pat_adv = {pattern_q[LED_NUM-2:0], pattern_q[LED_NUM-1]};
      2'b01: pat_adv = {pattern_q[0], pattern_q[LED_NUM-1:1]};
      2'b10: begin
        // Turn around on the end LED itself so each end is lit for one step only.
        if (dir_q == DIR_UP) begin
          if (pattern_q[LED_NUM-1]) begin
            pat_adv = pattern_q >> 1;
            dir_adv = DIR_DOWN;
          end else begin
            pat_adv = pattern_q << 1;
          end
        end else begin
          if (pattern_q[0]) begin
            pat_adv = pattern_q << 1;
            dir_adv = DIR_UP;
          end else begin
            pat_adv = pattern_q >> 1;
          end
        end
      end
      default: pat_adv = (&pattern_q) ? '0 : {pattern_q[LED_NUM-2:0], 1'b1};
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    step_cnt_d = step_cnt_q;
    pattern_d  = pattern_q;
    dir_d      = dir_q;
    mode_d     = mode_q;
    step_d     = 1'b0;
    if (mode != mode_q) begin
      cnt_d      = '0;
      step_cnt_d = 3'd0;
      pattern_d  = PAT_INIT;
      dir_d      = DIR_UP;
      mode_d     = mode;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_ONE;
      if (step) begin
        step_cnt_d = 3'd0;
        pattern_d  = pat_adv;
        dir_d      = dir_adv;
        step_d     = 1'b1;
      end else if (tick) begin
        step_cnt_d = step_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q      <= '0;
      step_cnt_q <= 3'd0;
      pattern_q  <= PAT_INIT;
      dir_q      <= DIR_UP;
      mode_q     <= mode;
      step_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      step_cnt_q <= step_cnt_d;
      pattern_q  <= pattern_d;
      dir_q      <= dir_d;
      mode_q     <= mode_d;
      step_q     <= step_d;
    end
  end

  assign led_out = ACTIVE_LOW ? ~pattern_q : pattern_q;
  assign step_o  = step_q;

endmodule

// File: tb/tb_water_led_multi.sv
// Bench for water_led_multi: three instances (4 LEDs active-low, 4 LEDs active-high,
// 2 LEDs active-high) share stimulus and are compared every cycle against a step-index model.
module tb_water_led_multi;

  localparam int TB_CNT_MAX = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [1:0] speed;
  logic [3:0] led_a, led_b;
  logic [1:0] led_c;
  logic       step_a, step_b, step_c;

  int n_checks = 0;
  int n_errors = 0;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  water_led_multi #(.LED_NUM(4), .CNT_W(3), .CNT_MAX(3'd4), .ACTIVE_LOW(1'b1)) u_a (
    .sys_clk(clk), .sys_rst(rst), .en(en), .mode(mode), .speed(speed),
    .led_out(led_a), .step_o(step_a));
  water_led_multi #(.LED_NUM(4), .CNT_W(3), .CNT_MAX(3'd4), .ACTIVE_LOW(1'b0)) u_b (
    .sys_clk(clk), .sys_rst(rst), .en(en), .mode(mode), .speed(speed),
    .led_out(led_b), .step_o(step_b));
  water_led_multi #(.LED_NUM(2), .CNT_W(3), .CNT_MAX(3'd4), .ACTIVE_LOW(1'b0)) u_c (
    .sys_clk(clk), .sys_rst(rst), .en(en), .mode(mode), .speed(speed),
    .led_out(led_c), .step_o(step_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pattern after k steps since reload, derived directly from the animation rules.
  function automatic logic [3:0] exp_led(input int k, input logic [1:0] md, input int n,
                                         input bit al);
    int pat, p, idx, ones;
    pat = 0;
    case (md)
      2'b00: pat = 1 << (k % n);
      2'b01: pat = 1 << ((n - (k % n)) % n);
      2'b10: begin
        p   = k % (2 * n - 2);
        idx = (p < n) ? p : (2 * n - 2 - p);
        pat = 1 << idx;
      end
      default: begin
        ones = (k + 1) % (n + 1);
        pat  = (1 << ones) - 1;
      end
    endcase
    if (al) pat = ~pat;
    pat = pat & ((1 << n) - 1);
    return pat[3:0];
  endfunction

  // Model: clocks-run counter, ticks since last step, step index since reload.
  bit         m_valid = 1'b0;
  int         m_run, m_ticks, m_k;
  logic [1:0] m_mode;
  bit         m_step;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_run = 0; m_ticks = 0; m_k = 0; m_mode = mode; m_step = 1'b0;
    end else if (mode != m_mode) begin
      m_run = 0; m_ticks = 0; m_k = 0; m_mode = mode; m_step = 1'b0;
    end else begin
      m_step = 1'b0;
      if (en) begin
        if (m_run == TB_CNT_MAX) begin
          m_run = 0;
          m_ticks++;
          if (m_ticks >= (1 << speed)) begin
            m_ticks = 0;
            m_k++;
            m_step = 1'b1;
          end
        end else begin
          m_run++;
        end
      end
    end
  end

  // Scoreboard: every cycle once the model has seen reset.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("mdl_led_a", 32'(led_a), 32'(exp_led(m_k, m_mode, 4, 1'b1)));
      chk("mdl_led_b", 32'(led_b), 32'(exp_led(m_k, m_mode, 4, 1'b0)));
      chk("mdl_led_c", 32'(led_c), 32'(exp_led(m_k, m_mode, 2, 1'b0)));
      chk("mdl_step_a", 32'(step_a), 32'(m_step));
      chk("mdl_step_b", 32'(step_b), 32'(m_step));
      chk("mdl_step_c", 32'(step_c), 32'(m_step));
    end
  end

  // Driver: wait (bounded) for the next step strobe, returning cycles waited.
  task automatic wait_step(input int budget, output int w);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!step_a && w < budget);
  endtask

  logic [3:0] rot_tab[4]  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic [3:0] bnc_tab[7]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  logic [1:0] bnc2_tab[3] = '{2'b10, 2'b01, 2'b10};
  logic [3:0] fill_tab[5] = '{4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0001};
  logic [3:0] rst_tab[4]  = '{4'b1101, 4'b1011, 4'b0111, 4'b1011};

  initial begin
    int w;
    rst = 1'b1; en = 1'b1; mode = 2'b00; speed = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_led_a", 32'(led_a), 32'(4'b1110));
    chk("rst_led_b", 32'(led_b), 32'(4'b0001));
    chk("rst_led_c", 32'(led_c), 32'(2'b01));
    chk("rst_step", 32'(step_a), 32'(1'b0));
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      wait_step(50, w);
      chk("rot_gap", 32'(w), 32'(5));
      chk("rot_led", 32'(led_a), 32'(rot_tab[i]));
    end

    mode = 2'b10;
    @(negedge clk);
    chk("bnc_start_b", 32'(led_b), 32'(4'b0001));
    chk("bnc_start_c", 32'(led_c), 32'(2'b01));
    chk("bnc_start_step", 32'(step_a), 32'(1'b0));
    for (int i = 0; i < 7; i++) begin
      wait_step(50, w);
      chk("bnc_gap", 32'(w), 32'(5));
      chk("bnc_led_b", 32'(led_b), 32'(bnc_tab[i]));
      if (i < 3) chk("bnc_led_c", 32'(led_c), 32'(bnc2_tab[i]));
    end

    mode = 2'b11;
    @(negedge clk);
    chk("fill_start", 32'(led_b), 32'(4'b0001));
    for (int i = 0; i < 5; i++) begin
      wait_step(50, w);
      chk("fill_gap", 32'(w), 32'(5));
      chk("fill_led", 32'(led_b), 32'(fill_tab[i]));
    end

    mode = 2'b00; speed = 2'd2;
    @(negedge clk);
    wait_step(100, w);
    chk("spd2_first_gap", 32'(w), 32'(20));
    chk("spd2_led1", 32'(led_a), 32'(4'b1101));
    wait_step(100, w);
    chk("spd2_gap", 32'(w), 32'(20));
    chk("spd2_led2", 32'(led_a), 32'(4'b1011));
    repeat (12) @(negedge clk);
    speed = 2'd0;
    wait_step(100, w);
    chk("spd_drop_gap", 32'(w), 32'(3));
    chk("spd_drop_led", 32'(led_a), 32'(4'b0111));

    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (13) @(negedge clk);
    chk("pause_frozen", 32'(led_a), 32'(4'b0111));
    en = 1'b1;
    wait_step(100, w);
    chk("pause_gap", 32'(w), 32'(3));
    chk("pause_led", 32'(led_a), 32'(4'b1110));

    repeat (4) @(negedge clk);
    mode = 2'b01;
    @(negedge clk);
    chk("mchg_step", 32'(step_a), 32'(1'b0));
    chk("mchg_led", 32'(led_a), 32'(4'b1110));
    wait_step(50, w);
    chk("mchg_gap", 32'(w), 32'(5));
    chk("mchg_led_next", 32'(led_a), 32'(4'b0111));

    mode = 2'b10;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wait_step(50, w);
      chk("mrst_pre_gap", 32'(w), 32'(5));
      chk("mrst_pre_led", 32'(led_a), 32'(rst_tab[i]));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_led_a", 32'(led_a), 32'(4'b1110));
    chk("mrst_led_b", 32'(led_b), 32'(4'b0001));
    wait_step(50, w);
    chk("mrst_gap", 32'(w), 32'(5));
    chk("mrst_led_up", 32'(led_a), 32'(4'b1101));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
